// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
//   mul_state_t : FSM state encoding (IDLE -> CALC -> FIX -> IDLE)
//   MAX_WIDTH   : widest operand abs_w() can handle
//   abs_w()     : magnitude of a two's-complement value of arbitrary width
package seq_mul_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX} mul_state_t;

  localparam int MAX_WIDTH = 64;

  // The value is treated as a width-bit two's-complement number held in the
  // low bits of a MAX_WIDTH container; the result is its magnitude, also in
  // the low width bits. The most negative value maps to 2^(width-1), which
  // still fits when the result is read back as unsigned.
  function automatic logic [MAX_WIDTH-1:0] abs_w(input logic [MAX_WIDTH-1:0] value,
                                                  input int width);
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] sign_bit;
    mask     = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    sign_bit = MAX_WIDTH'(1) << (width - 1);
    if ((value & sign_bit) != '0)
      abs_w = (~value + MAX_WIDTH'(1)) & mask;
    else
      abs_w = value & mask;
  endfunction

endpackage

// File: rtl/mul_partial_step.sv
// One retirement step of the shift-add multiplier (purely combinational).
//   acc      in  accumulator, 2*WIDTH+BITS_PER_CYCLE bits
//   mcand    in  multiplicand magnitude, WIDTH bits
//   m        in  low BITS_PER_CYCLE bits of the multiplier register
//   acc_next out (acc + (m*mcand << WIDTH)) >> BITS_PER_CYCLE
module mul_partial_step #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH+BITS_PER_CYCLE-1:0] acc,
  input  logic [WIDTH-1:0]                  mcand,
  input  logic [BITS_PER_CYCLE-1:0]         m,
  output logic [2*WIDTH+BITS_PER_CYCLE-1:0] acc_next
);

  localparam int PW = WIDTH + BITS_PER_CYCLE;

  logic [PW-1:0]                     partial;
  logic [2*WIDTH+BITS_PER_CYCLE-1:0] sum;

  // The partial product enters at the top of the accumulator; after the
  // right shift, earlier contributions line up at their true weights once
  // all multiplier bits are retired. The accumulator stays below 2^(2W)
  // between steps, so the sum cannot overflow 2W+K bits.
  assign partial  = PW'(m) * PW'(mcand);
  assign sum      = acc + {partial, {WIDTH{1'b0}}};
  assign acc_next = sum >> BITS_PER_CYCLE;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, BITS_PER_CYCLE multiplier bits per cycle,
// unsigned or two's-complement operands selected per operation.
//   clk, rstn    clock and synchronous active-low reset
//   start        request, accepted only while ready
//   signed_mode  operand interpretation, sampled with start
//   abort        cancels an operation in CALC or FIX
//   a, b         multiplicand and multiplier, sampled with start
//   ready        high in IDLE
//   busy         high in CALC or FIX
//   done         one-cycle pulse when a new product is available
//   product      registered 2*WIDTH-bit result, held until the next done
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int K     = BITS_PER_CYCLE;
  localparam int N     = WIDTH / K;
  localparam int CNT_W = $clog2(N + 1);
  localparam int ACC_W = 2 * WIDTH + K;

  mul_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_step;
  logic             neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Signed operands are reduced to magnitudes up front so the datapath is
  // always unsigned; the sign is reapplied once in FIX.
  assign a_mag = signed_mode ? WIDTH'(abs_w(MAX_WIDTH'(a), WIDTH)) : a;
  assign b_mag = signed_mode ? WIDTH'(abs_w(MAX_WIDTH'(b), WIDTH)) : b;

  assign ready = (state == IDLE);
  assign busy  = (state == CALC) || (state == FIX);

  mul_partial_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (K)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .m        (mplier[K-1:0]),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // start beats a simultaneous abort here since abort is only
          // meaningful once an operation is in flight
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt    <= CNT_W'(N);
            state  <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            acc    <= acc_step;
            mplier <= mplier >> K;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
              state <= FIX;
          end
        end
        FIX: begin
          if (!abort) begin
            product <= neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
            done    <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier: a K=1 and a K=4 instance share all inputs
// and are checked against an arithmetic reference product.
module tb_seq_multiplier;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        signed_mode;
  logic        abort;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready_k1, busy_k1, done_k1;
  logic        ready_k4, busy_k4, done_k4;
  logic [31:0] product_k1, product_k4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut_k1 (
    .clk(clk), .rstn(rstn), .start(start), .signed_mode(signed_mode),
    .abort(abort), .a(a), .b(b), .ready(ready_k1), .busy(busy_k1),
    .done(done_k1), .product(product_k1)
  );

  seq_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut_k4 (
    .clk(clk), .rstn(rstn), .start(start), .signed_mode(signed_mode),
    .abort(abort), .a(a), .b(b), .ready(ready_k4), .busy(busy_k4),
    .done(done_k4), .product(product_k4)
  );

  // Exact product as plain integer arithmetic, truncated to 32 bits.
  function automatic logic [31:0] ref_product(input logic [15:0] x,
                                              input logic [15:0] y,
                                              input logic sm);
    longint sx, sy;
    sx = sm ? longint'($signed(x)) : longint'(x);
    sy = sm ? longint'($signed(y)) : longint'(y);
    return 32'(sx * sy);
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Issue one operation to both instances and wait for both done pulses.
  // Latencies count edges after the accepting edge; -1 means no done seen.
  task automatic apply_stimulus(input logic [15:0] ia, input logic [15:0] ib,
                                input logic ism, input logic iab,
                                output logic [31:0] p1, output logic [31:0] p4,
                                output int lat1, output int lat4);
    @(negedge clk);
    a = ia; b = ib; signed_mode = ism; start = 1'b1; abort = iab;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    lat1 = -1; lat4 = -1; p1 = '0; p4 = '0;
    for (int c = 1; c <= 40 && (lat1 < 0 || lat4 < 0); c++) begin
      @(posedge clk); #1;
      if (done_k1 && lat1 < 0) begin lat1 = c; p1 = product_k1; end
      if (done_k4 && lat4 < 0) begin lat4 = c; p4 = product_k4; end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_op(input string tag, input logic [31:0] exp,
                          input logic [31:0] p1, input logic [31:0] p4,
                          input int lat1, input int lat4);
    check_output({tag, "_k1_product"}, p1, exp);
    check_output({tag, "_k4_product"}, p4, exp);
    check_output({tag, "_k1_latency"}, lat1, 17);
    check_output({tag, "_k4_latency"}, lat4, 5);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] p1, p4;
    int          lat1, lat4;
    logic [31:0] exp_q1[$], exp_q4[$];
    int          acc1, acc4, ndone;

    vecs.push_back('{16'h0003, 16'h0005, 1'b0, 32'h0000000F});
    vecs.push_back('{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
    vecs.push_back('{16'h0000, 16'h1234, 1'b0, 32'h00000000});
    vecs.push_back('{16'h1234, 16'h5678, 1'b0, 32'h06260060});
    vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 32'h40000000});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF});

    rstn = 1'b0; start = 1'b0; abort = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_product", product_k1, 32'h0);
    check_output("reset_ready", ready_k1, 1);
    check_output("reset_busy", busy_k1, 0);
    check_output("reset_done", done_k1, 0);
    @(negedge clk) rstn = 1'b1;

    // Directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sm, 1'b0, p1, p4, lat1, lat4);
      check_op($sformatf("vec%0d", i), vecs[i].exp, p1, p4, lat1, lat4);
    end

    // start together with abort in IDLE: the operation must still run
    apply_stimulus(16'h0010, 16'h0020, 1'b0, 1'b1, p1, p4, lat1, lat4);
    check_op("start_abort", 32'h00000200, p1, p4, lat1, lat4);

    // start held high with changing operands
    acc1 = 0; acc4 = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (c < 40) begin
        a = 16'($urandom); b = 16'($urandom);
        signed_mode = 1'($urandom_range(0, 1)); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (start && ready_k1) begin exp_q1.push_back(ref_product(a, b, signed_mode)); acc1++; end
      if (start && ready_k4) begin exp_q4.push_back(ref_product(a, b, signed_mode)); acc4++; end
      @(posedge clk); #1;
      if (done_k1) begin
        if (exp_q1.size() == 0) check_output("hs_k1_extra_done", 1, 0);
        else check_output("hs_k1_product", product_k1, exp_q1.pop_front());
      end
      if (done_k4) begin
        if (exp_q4.size() == 0) check_output("hs_k4_extra_done", 1, 0);
        else check_output("hs_k4_product", product_k4, exp_q4.pop_front());
      end
    end
    check_output("hs_k1_accepts", acc1, 3);
    check_output("hs_k4_accepts", acc4, 7);
    check_output("hs_k1_pending", exp_q1.size(), 0);
    check_output("hs_k4_pending", exp_q4.size(), 0);

    // Abort at CALC cycle 5 (K=4 instance is in FIX at that edge)
    apply_stimulus(16'h0003, 16'h0005, 1'b0, 1'b0, p1, p4, lat1, lat4);
    check_op("pre_abort", 32'h0000000F, p1, p4, lat1, lat4);
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_output("calc_busy", busy_k1, 1);
    check_output("calc_ready", ready_k1, 0);
    repeat (4) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_output("abort_ready", ready_k1, 1);
    check_output("abort_busy", busy_k1, 0);
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done_k1 || done_k4) ndone++;
    end
    check_output("abort_no_done", ndone, 0);
    check_output("abort_k1_product", product_k1, 32'h0000000F);
    check_output("abort_k4_product", product_k4, 32'h0000000F);

    // Reset in the middle of CALC
    @(negedge clk);
    a = 16'h00FF; b = 16'h0101; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rstn = 1'b0;
    @(posedge clk); #1;
    check_output("midreset_k1_product", product_k1, 32'h0);
    check_output("midreset_k4_product", product_k4, 32'h0);
    check_output("midreset_ready", ready_k1, 1);
    check_output("midreset_busy", busy_k1, 0);
    check_output("midreset_done", done_k1, 0);
    @(negedge clk) rstn = 1'b1;

    // Random sweep against the reference model
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
      apply_stimulus(ra, rb, rs, 1'b0, p1, p4, lat1, lat4);
      check_op("rand", ref_product(ra, rb, rs), p1, p4, lat1, lat4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
